// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the coin-return sequencer.
package change_dispenser_pkg;

    localparam int AMT_W = 8;
    localparam int HOP_N = 3;

    localparam int HOP_HI  = 2;
    localparam int HOP_MID = 1;
    localparam int HOP_LO  = 0;

    typedef logic [AMT_W-1:0] amt_t;
    typedef logic [HOP_N-1:0] hop_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_EJECT  = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    typedef logic [1:0] fault_code_t;

    localparam fault_code_t FAULT_NONE      = 2'd0;
    localparam fault_code_t FAULT_EXHAUSTED = 2'd1;
    localparam fault_code_t FAULT_TIMEOUT   = 2'd2;

    function automatic amt_t sat_inc(input amt_t v);
        return (v == '1) ? v : v + amt_t'(1);
    endfunction

endpackage

// File: rtl/denom_select.sv
// Greedy hopper picker: highest non-empty denomination that still fits the owed amount.
module denom_select
    import change_dispenser_pkg::*;
(
    input  logic [AMT_W-1:0] remaining,
    input  logic [HOP_N-1:0] hopper_empty,
    input  logic [AMT_W-1:0] denom_hi,
    input  logic [AMT_W-1:0] denom_mid,
    input  logic [AMT_W-1:0] denom_lo,
    output logic [HOP_N-1:0] sel,
    output logic             valid,
    output logic [AMT_W-1:0] denom
);

    amt_t denom_tab [HOP_N];

    assign denom_tab[HOP_HI]  = denom_hi;
    assign denom_tab[HOP_MID] = denom_mid;
    assign denom_tab[HOP_LO]  = denom_lo;

    // Scan from the top index down so the first hit is the largest coin.
    always_comb begin
        sel   = '0;
        valid = 1'b0;
        denom = '0;
        for (int h = HOP_N - 1; h >= 0; h--) begin
            if (!valid && !hopper_empty[h] && (denom_tab[h] <= remaining)) begin
                sel[h] = 1'b1;
                valid  = 1'b1;
                denom  = denom_tab[h];
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Coin-return sequencer driving three hoppers with a req/ack handshake.
// Optional ack timeout enabled by defining CHANGE_DISPENSER_TIMEOUT_EN.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int DENOM_HI    = 5,
    parameter int DENOM_MID   = 2,
    parameter int DENOM_LO    = 1,
    parameter int GAP_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             change_start,
    input  logic [AMT_W-1:0] change_amount,
    input  logic [HOP_N-1:0] hopper_empty,
    input  logic             eject_ack,
    output logic [HOP_N-1:0] eject_req,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [AMT_W-1:0] remaining,
    output logic [AMT_W-1:0] coin_count
);

    localparam int CNT_W = 16;

    state_t          state, state_nx;
    amt_t            sel_denom, sel_denom_nx;
    amt_t            remaining_nx, coin_count_nx;
    hop_vec_t        eject_req_nx;
    fault_code_t     fault_code_nx;
    logic            done_nx, fault_nx, busy_nx;
    logic [CNT_W-1:0] gap_cnt, gap_cnt_nx;

    hop_vec_t pick_sel;
    logic     pick_valid;
    amt_t     pick_denom;
    logic     ack_hit, timeout_hit;

    denom_select u_denom_select (
        .remaining    (remaining),
        .hopper_empty (hopper_empty),
        .denom_hi     (AMT_W'(DENOM_HI)),
        .denom_mid    (AMT_W'(DENOM_MID)),
        .denom_lo     (AMT_W'(DENOM_LO)),
        .sel          (pick_sel),
        .valid        (pick_valid),
        .denom        (pick_denom)
    );

    assign ack_hit = (state == ST_EJECT) && eject_ack;

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    logic [CNT_W-1:0] to_cnt;

    // Counts completed EJECT cycles; restarts from zero on every new request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                to_cnt <= '0;
        else if (state == ST_EJECT) to_cnt <= to_cnt + CNT_W'(1);
        else                       to_cnt <= '0;
    end

    assign timeout_hit = (state == ST_EJECT) && !eject_ack &&
                         (to_cnt == CNT_W'(ACK_TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (change_start) state_nx = ST_SELECT;
            ST_SELECT: begin
                if (remaining == '0)  state_nx = ST_IDLE;
                else if (pick_valid)  state_nx = ST_EJECT;
                else                  state_nx = ST_IDLE;
            end
            ST_EJECT: begin
                if (ack_hit)          state_nx = ST_GAP;
                else if (timeout_hit) state_nx = ST_IDLE;
            end
            ST_GAP:    if (gap_cnt == '0) state_nx = ST_SELECT;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath.
    always_comb begin
        remaining_nx  = remaining;
        coin_count_nx = coin_count;
        fault_code_nx = fault_code;
        eject_req_nx  = eject_req;
        sel_denom_nx  = sel_denom;
        gap_cnt_nx    = gap_cnt;
        done_nx       = 1'b0;
        fault_nx      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (change_start) begin
                    remaining_nx  = change_amount;
                    coin_count_nx = '0;
                    fault_code_nx = FAULT_NONE;
                end
            end
            ST_SELECT: begin
                if (remaining == '0) begin
                    done_nx = 1'b1;
                end else if (pick_valid) begin
                    eject_req_nx = pick_sel;
                    sel_denom_nx = pick_denom;
                end else begin
                    fault_nx      = 1'b1;
                    fault_code_nx = FAULT_EXHAUSTED;
                end
            end
            ST_EJECT: begin
                if (ack_hit) begin
                    eject_req_nx  = '0;
                    remaining_nx  = remaining - sel_denom;
                    coin_count_nx = sat_inc(coin_count);
                    gap_cnt_nx    = CNT_W'(GAP_CYCLES - 1);
                end else if (timeout_hit) begin
                    eject_req_nx  = '0;
                    fault_nx      = 1'b1;
                    fault_code_nx = FAULT_TIMEOUT;
                end
            end
            ST_GAP: begin
                if (gap_cnt != '0) gap_cnt_nx = gap_cnt - CNT_W'(1);
            end
            default: ;
        endcase
        busy_nx = (state_nx != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eject_req  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FAULT_NONE;
            remaining  <= '0;
            coin_count <= '0;
            sel_denom  <= '0;
            gap_cnt    <= '0;
        end else begin
            eject_req  <= eject_req_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            fault      <= fault_nx;
            fault_code <= fault_code_nx;
            remaining  <= remaining_nx;
            coin_count <= coin_count_nx;
            sel_denom  <= sel_denom_nx;
            gap_cnt    <= gap_cnt_nx;
        end
    end

endmodule
